result_sram_streamer: RTL
=========================

Name: result_sram_streamer

Overview:
- Reader for the result SRAM that the Bicubic engine writes.
- After a START pulse, it reads the TW x TH result image in raster order, with address = row*TW + col.
- Pixels leave on a valid/ready byte stream with row-end and last markers, for host readout and for the on-chip checker.
- It sits beside the result SRAM and owns that SRAM's read port while BUSY.

Parameters:
- ADDR_W, 12, result SRAM address width (63*63 = 3969 < 4096).
- DATA_W, 8, pixel width.
- DIM_W, 6, width of TW/TH.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- TW  in  DIM_W  target width; latched on accepted START.
- TH  in  DIM_W  target height; latched on accepted START.
- SRAM_CEN  out  1  read enable, active-high.
- SRAM_A  out  ADDR_W  read address.
- SRAM_Q  in  DATA_W  read data, valid exactly 1 cycle after SRAM_CEN.
- OUT_VALID  out  1  stream beat valid.
- OUT_READY  in  1  sink ready.
- OUT_DATA  out  DATA_W  pixel.
- OUT_ROW_END  out  1  beat is the last of its row.
- OUT_LAST  out  1  beat is the final pixel of the image.
- BUSY  out  1  high from accepted START until FINISH.
- FINISH  out  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset (asynchronous, RST_N=0): all outputs 0; state IDLE; FIFO empty; counters 0. Reset mid-transfer aborts with no FINISH; after release the block sits in IDLE.
- State machine IDLE -> ISSUE -> DRAIN -> FIN -> IDLE.
  - IDLE: START=1 latches TW/TH and sets BUSY=1 the next cycle. If TW==0 or TH==0, go to FIN (no beats, no reads); else go to ISSUE.
  - ISSUE: assert SRAM_CEN with SRAM_A = addr when fifo_count + inflight < 2. Then addr++ and col++; when col==TW-1, col->0 and row++. After issuing address TW*TH-1, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to FIN.
  - FIN: FINISH=1 for one cycle, BUSY->0, return to IDLE.
- START while not IDLE is ignored and does not re-latch TW/TH.
- Addressing: addr is an incremental counter; no multiplier. SRAM_A is held at its last value when CEN=0.
- Tags: each read carries {row_end, last}. row_end = (col==TW-1); last = row_end && (row==TH-1). The tag is delayed 1 cycle alongside the read.
- Buffering: 2-entry FIFO captures SRAM_Q plus tag one cycle after CEN. Credit rule: never overflow, and no read is ever re-issued.
- Stream rules:
  - OUT_* is driven from the FIFO head; OUT_VALID = !empty.
  - A beat transfers on OUT_VALID && OUT_READY.
  - Once OUT_VALID is high, OUT_DATA/ROW_END/LAST hold stable until the beat transfers.
  - No combinational path from OUT_READY to OUT_VALID.
- Throughput: 1 beat/cycle sustained with OUT_READY held 1.
- Latency: first OUT_VALID comes 3 cycles after the START edge (latch, issue, capture).
- Simultaneous push and pop on a full or one-entry FIFO: count unchanged, order preserved.
- Maximum image 63x63: final addr 3968, no wrap. addr never exceeds TW*TH-1.

Optional Feature:
- Macro: RESULT_STREAM_CHECKSUM_EN.
- Enabled: adds output CHECKSUM [15:0].
  - Cleared on accepted START.
  - Adds the zero-extended OUT_DATA on every transferred beat, modulo 2^16.
  - Stable and valid in the FIN cycle and held until the next START.
- Disabled: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package result_stream_pkg holds:
  - ADDR_W/DATA_W/DIM_W defaults.
  - State enum typedef (IDLE, ISSUE, DRAIN, FIN).
  - Struct typedef {data, row_end, last} for FIFO entries.
- One sub-module: stream_fifo2, a 2-entry synchronous FIFO with full/empty/count, parameterised on the entry type.

Test Plan:
- TW=4, TH=3, SRAM preloaded with mem[k]=k, OUT_READY=1.
  - 12 beats with data 0..11.
  - ROW_END on data 3, 7 and 11; LAST only on data 11.
  - FINISH pulses once; BUSY high throughout.
- Same image with OUT_READY toggling in a random 50% pattern.
  - Identical 12-beat sequence; no drops or duplicates.
  - Held OUT_DATA stable while stalled; at most 2 reads outstanding ahead of the sink.
- TW=0, TH=5: no SRAM_CEN and no OUT_VALID; FINISH pulses 2 cycles after START.
- TW=TH=63, mem[k]=k&0xFF:
  - 3969 beats; final SRAM_A = 3968.
  - LAST on beat 3969; with CHECKSUM_EN, CHECKSUM = sum (mod 2^16).
- START pulsed again mid-transfer with TW=2: ignored; the original 4x3 transfer completes unchanged.
- RST_N asserted after the 5th beat:
  - All outputs go to 0 immediately; no FINISH.
  - A new START with a 2x2 image then produces 4 correct beats.

Source files
------------

// File: rtl/result_stream_pkg.sv
// Shared types and default widths for the result SRAM streamer.
package result_stream_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int DIM_W_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  row_end;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO; head entry is always presented on dout.
// Push into a full FIFO is accepted only together with a pop.
module stream_fifo2 #(
  parameter type T = logic [7:0]
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       push,
  input  T           din,
  input  logic       pop,
  output T           dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  T           head_r;
  T           tail_r;
  logic [1:0] count_r;
  logic       push_s;
  logic       pop_s;

  // Qualify push/pop against occupancy.
  always_comb begin
    pop_s  = pop && (count_r != 2'd0);
    push_s = push && ((count_r != 2'd2) || pop_s);
  end

  // Storage and occupancy; simultaneous push/pop keeps count and order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) head_r <= din;
          else                 tail_r <= din;
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_r <= din;
          end else begin
            head_r <= tail_r;
            tail_r <= din;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign dout  = head_r;
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);
  assign count = count_r;

endmodule

// File: rtl/result_sram_streamer.sv
// Raster-order reader of the Bicubic result SRAM onto a valid/ready byte stream.
// Optional CHECKSUM output is built when RESULT_STREAM_CHECKSUM_EN is defined.
module result_sram_streamer
  import result_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [DIM_W-1:0]  TW,
  input  logic [DIM_W-1:0]  TH,
  output logic              SRAM_CEN,
  output logic [ADDR_W-1:0] SRAM_A,
  input  logic [DATA_W-1:0] SRAM_Q,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_ROW_END,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic              FINISH
`ifdef RESULT_STREAM_CHECKSUM_EN
  , output logic [15:0]     CHECKSUM
`endif
);

  localparam logic [DIM_W-1:0]  DIM_ZERO  = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0]  DIM_ONE   = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_r;
  state_e            state_nx_s;
  logic [DIM_W-1:0]  tw_r;
  logic [DIM_W-1:0]  th_r;
  logic [DIM_W-1:0]  col_r;
  logic [DIM_W-1:0]  row_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] a_hold_r;
  logic              qv_r;
  logic              tag_row_end_r;
  logic              tag_last_r;
  logic              busy_r;
  logic              finish_r;

  logic              start_ok_s;
  logic              zero_dim_s;
  logic              pop_s;
  logic [2:0]        occ_s;
  logic              issue_s;
  logic              row_end_s;
  logic              last_s;

  beat_t             push_beat_s;
  beat_t             head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [1:0]        fifo_count_s;

  // Handshake qualifiers and credit: occupancy after this cycle's pop, including the read in flight.
  always_comb begin
    start_ok_s = (state_r == IDLE) && START;
    zero_dim_s = (TW == DIM_ZERO) || (TH == DIM_ZERO);
    pop_s      = OUT_READY && !fifo_empty_s;
    occ_s      = {1'b0, fifo_count_s} + {2'b00, qv_r} - {2'b00, pop_s};
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s && zero_dim_s) state_nx_s = FIN;
        else if (start_ok_s)          state_nx_s = ISSUE;
        else                          state_nx_s = IDLE;
      end
      ISSUE: begin
        if (issue_s && last_s) state_nx_s = DRAIN;
        else                   state_nx_s = ISSUE;
      end
      DRAIN: begin
        if (fifo_empty_s && !qv_r) state_nx_s = FIN;
        else                       state_nx_s = DRAIN;
      end
      FIN:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Read issue, tag generation and SRAM port drive.
  always_comb begin
    issue_s   = (state_r == ISSUE) && (occ_s < 3'd2);
    row_end_s = (col_r == (tw_r - DIM_ONE));
    last_s    = row_end_s && (row_r == (th_r - DIM_ONE));
    SRAM_CEN  = issue_s;
    if (issue_s) SRAM_A = addr_r;
    else         SRAM_A = a_hold_r;
  end

  // Dimension latch and raster counters; counters stop on the final address.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tw_r     <= DIM_ZERO;
      th_r     <= DIM_ZERO;
      col_r    <= DIM_ZERO;
      row_r    <= DIM_ZERO;
      addr_r   <= ADDR_ZERO;
      a_hold_r <= ADDR_ZERO;
    end else if (start_ok_s) begin
      tw_r   <= TW;
      th_r   <= TH;
      col_r  <= DIM_ZERO;
      row_r  <= DIM_ZERO;
      addr_r <= ADDR_ZERO;
    end else if (issue_s) begin
      a_hold_r <= addr_r;
      if (!last_s) begin
        addr_r <= addr_r + ADDR_ONE;
        if (row_end_s) begin
          col_r <= DIM_ZERO;
          row_r <= row_r + DIM_ONE;
        end else begin
          col_r <= col_r + DIM_ONE;
        end
      end
    end
  end

  // Tag travels one cycle behind its read, matching SRAM_Q.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      qv_r          <= 1'b0;
      tag_row_end_r <= 1'b0;
      tag_last_r    <= 1'b0;
    end else begin
      qv_r          <= issue_s;
      tag_row_end_r <= row_end_s;
      tag_last_r    <= last_s;
    end
  end

  // BUSY drops in the same cycle FINISH rises.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_r   <= 1'b0;
      finish_r <= 1'b0;
    end else begin
      busy_r   <= (state_nx_s != IDLE);
      finish_r <= (state_r == FIN);
    end
  end

  always_comb begin
    push_beat_s         = '0;
    push_beat_s.data    = DATA_W_DEF'(SRAM_Q);
    push_beat_s.row_end = tag_row_end_r;
    push_beat_s.last    = tag_last_r;
  end

  stream_fifo2 #(
    .T (beat_t)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (qv_r),
    .din   (push_beat_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign OUT_VALID   = !fifo_empty_s;
  assign OUT_DATA    = DATA_W'(head_s.data);
  assign OUT_ROW_END = head_s.row_end;
  assign OUT_LAST    = head_s.last;
  assign BUSY        = busy_r;
  assign FINISH      = finish_r;

`ifdef RESULT_STREAM_CHECKSUM_EN
  logic [15:0] checksum_r;

  // Running sum of transferred beats, restarted by an accepted START.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)          checksum_r <= 16'd0;
    else if (start_ok_s) checksum_r <= 16'd0;
    else if (pop_s)      checksum_r <= checksum_r + 16'(OUT_DATA);
    else                 checksum_r <= checksum_r;
  end

  assign CHECKSUM = checksum_r;
`endif

endmodule
